// File: rtl/tx_framer_pkg.sv
// Shared switch package: byte constants for the Ethernet framing, the
// reflected CRC-32 constants, and the transmit framer state enumeration.
package switch_pkg;
  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG, DRAIN
  } tx_state_t;
endpackage

// File: rtl/tx_framer_if.sv
// Queue-side handshake between the crossbar output FIFO and the framer.
//   frame_avail_i : at least one complete frame is queued
//   q_empty_i     : queue empty
//   q_rd_o        : read strobe, q_data_i valid the following cycle
//   q_data_i      : {last, byte}
// master = queue side, slave = framer side.
interface tx_framer_if;
  import switch_pkg::*;
  logic       frame_avail_i;
  logic       q_empty_i;
  logic       q_rd_o;
  logic [8:0] q_data_i;

  modport master (output frame_avail_i, q_empty_i, q_data_i, input q_rd_o);
  modport slave  (input frame_avail_i, q_empty_i, q_data_i, output q_rd_o);
endinterface

// File: rtl/tx_framer_crc.sv
// crc32_update_8: combinational one-byte step of the reflected CRC-32
// (poly 0xEDB88320), LSB of the byte first. No init, no final complement.
//   crc      : current register
//   data     : byte to absorb
//   crc_next : register after the byte
module crc32_update_8
  import switch_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  always_comb begin
    crc_next = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC32_POLY_REFL) : (crc_next >> 1);
  end
endmodule

// File: rtl/tx_framer.sv
// tx_framer: egress framer. Pulls a {last,data} frame from the output queue,
// sends preamble/SFD, the frame bytes, optional zero pad and a regenerated
// CRC-32 FCS, then holds the inter-frame gap.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   q            : queue handshake (tx_framer_if.slave)
//   tx_data      : registered TX byte
//   tx_ctrl      : registered, 1 while tx_data is preamble..FCS
//   busy_o       : state != IDLE
//   frame_sent_o : pulse with the last FCS byte
//   underrun_o   : pulse when the queue runs dry mid-frame
// Build option: define TX_PAD_EN to zero-pad runts up to P_MIN_FRAME.
module tx_framer
  import switch_pkg::*;
#(
  parameter int P_PREAMBLE_LEN = 7,
  parameter int P_MIN_FRAME    = 60,
  parameter int P_IFG_CYCLES   = 12
)(
  input  logic        clk,
  input  logic        reset,
  tx_framer_if.slave  q,
  output logic [7:0]  tx_data,
  output logic        tx_ctrl,
  output logic        busy_o,
  output logic        frame_sent_o,
  output logic        underrun_o
);
  localparam logic [2:0] ST_IDLE     = IDLE;
  localparam logic [2:0] ST_PREAMBLE = PREAMBLE;
  localparam logic [2:0] ST_SFD      = SFD;
  localparam logic [2:0] ST_DATA     = DATA;
  localparam logic [2:0] ST_PAD      = PAD;
  localparam logic [2:0] ST_FCS      = FCS;
  localparam logic [2:0] ST_IFG      = IFG;
  localparam logic [2:0] ST_DRAIN    = DRAIN;

`ifdef TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam logic [15:0] PRE_LAST = 16'(P_PREAMBLE_LEN - 1);
  localparam logic [15:0] IFG_LAST = 16'(P_IFG_CYCLES - 1);
  localparam logic [15:0] FCS_LAST = 16'd3;
  localparam logic [10:0] MIN_LEN  = 11'(P_MIN_FRAME);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [10:0] len, len_nxt;
  logic [31:0] crc, crc_nxt;
  logic [7:0]  crc_byte;
  logic        rd_q;       // a read was issued last cycle, q_data_i is fresh
  logic        need_rd;
  logic        underrun_det;
  logic        start;

  assign start   = q.frame_avail_i & ~q.q_empty_i;
  assign len_nxt = (len == 11'h7FF) ? len : len + 11'd1;

  // DRAIN stops reading once the fresh byte carries last
  always_comb begin
    need_rd = 1'b0;
    case (state)
      ST_SFD:   need_rd = 1'b1;
      ST_DATA:  need_rd = ~q.q_data_i[8];
      ST_DRAIN: need_rd = ~(rd_q & q.q_data_i[8]);
      default:  need_rd = 1'b0;
    endcase
  end

  assign q.q_rd_o     = need_rd & ~q.q_empty_i;
  assign underrun_det = ((state == ST_SFD) | (state == ST_DATA)) & need_rd & q.q_empty_i;
  assign busy_o       = (state != ST_IDLE);
  assign crc_byte     = (state == ST_PAD) ? 8'h00 : q.q_data_i[7:0];

  crc32_update_8 u_crc (.crc(crc), .data(crc_byte), .crc_next(crc_nxt));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      len          <= '0;
      crc          <= CRC32_INIT;
      rd_q         <= 1'b0;
      tx_data      <= 8'h00;
      tx_ctrl      <= 1'b0;
      frame_sent_o <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      rd_q         <= q.q_rd_o;
      tx_data      <= 8'h00;
      tx_ctrl      <= 1'b0;
      frame_sent_o <= 1'b0;
      underrun_o   <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_PREAMBLE;
          cnt   <= '0;
          crc   <= CRC32_INIT;
        end
        ST_PREAMBLE: begin
          tx_data <= PREAMBLE_BYTE;
          tx_ctrl <= 1'b1;
          cnt     <= cnt + 16'd1;
          if (cnt == PRE_LAST) state <= ST_SFD;
        end
        ST_SFD: begin
          if (underrun_det) begin
            underrun_o <= 1'b1;
            state      <= ST_DRAIN;
          end else begin
            tx_data <= SFD_BYTE;
            tx_ctrl <= 1'b1;
            len     <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          // the byte in hand is dropped on underrun: the frame is already corrupt
          if (underrun_det) begin
            underrun_o <= 1'b1;
            state      <= ST_DRAIN;
          end else begin
            tx_data <= q.q_data_i[7:0];
            tx_ctrl <= 1'b1;
            crc     <= crc_nxt;
            len     <= len_nxt;
            if (q.q_data_i[8]) begin
              cnt   <= '0;
              state <= (PAD_EN && (len_nxt < MIN_LEN)) ? ST_PAD : ST_FCS;
            end
          end
        end
        ST_PAD: begin
          tx_data <= 8'h00;
          tx_ctrl <= 1'b1;
          crc     <= crc_nxt;
          len     <= len_nxt;
          if (len_nxt >= MIN_LEN) begin
            cnt   <= '0;
            state <= ST_FCS;
          end
        end
        ST_FCS: begin
          tx_data <= ~crc[7:0];
          tx_ctrl <= 1'b1;
          crc     <= {8'h00, crc[31:8]};
          cnt     <= cnt + 16'd1;
          if (cnt == FCS_LAST) begin
            frame_sent_o <= 1'b1;
            cnt          <= '0;
            state        <= ST_IFG;
          end
        end
        ST_IFG: begin
          cnt <= cnt + 16'd1;
          // jump straight into the next preamble so the gap is exactly P_IFG_CYCLES
          if (cnt == IFG_LAST) begin
            cnt <= '0;
            if (start) begin
              state <= ST_PREAMBLE;
              crc   <= CRC32_INIT;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: if (rd_q && q.q_data_i[8]) begin
          cnt   <= '0;
          state <= ST_IFG;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
